mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sequences each access as a request/ack transaction and returns read data with a one-cycle valid pulse.
- Raises per-requester busy flags that feed the pipeline stall controller, the same way the execute and memory stages report busy today.
- Memory stage has priority; a starvation counter bounds how long fetch can be locked out.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 3, max consecutive mm grants while if_req is pending before fetch is forced; 0 = fetch always wins ties.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetch read data; registered
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_busy  out  1  if_req & ~if_valid
- mm_req  in  1  memory-stage request; level, held until mm_valid
- mm_we  in  1  1 = store, 0 = load
- mm_addr  in  ADDR_W  data address
- mm_wdata  in  DATA_W  store data
- mm_rdata  out  DATA_W  load data; registered
- mm_valid  out  1  one-cycle completion pulse, loads and stores
- mm_busy  out  1  mm_req & ~mm_valid
- mem_req  out  1  backing memory request; held until mem_ack
- mem_we  out  1  latched write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  transaction complete, single-cycle

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_MM, RESP_IF, RESP_MM.
- Reset: state IDLE; starve_cnt 0; mem_req/mem_we 0; mem_addr/mem_wdata 0; if_rdata/mm_rdata 0; if_valid/mm_valid 0.

IDLE, arbitration in cycle t:
- mm wins if mm_req & (~if_req | starve_cnt < STARVE_MAX).
- Otherwise if wins if if_req.
- Nothing happens if neither is requesting.
- On grant: latch the winner's addr, we (fetch forces 0) and wdata (fetch forces 0) into the mem_* registers; set mem_req=1 from t+1; go to BUSY_IF or BUSY_MM.

starve_cnt:
- mm grant with if_req high: +1, saturating at STARVE_MAX.
- Any if grant: cleared to 0.
- mm grant with if_req low: unchanged.

BUSY_x:
- mem_* held constant.
- On mem_ack: capture mem_rdata into x_rdata, except on a store, where mm_rdata holds its old value. Clear mem_req next cycle, go to RESP_x.

RESP_x:
- x_valid=1 for exactly this cycle; no new grant is made; next state IDLE.
- This blocks double service of a level request that is still high while valid is seen.

Latency and throughput:
- Grant at t, mem_ack at t+k (k≥1), valid at t+k+1, earliest next grant at t+k+2.
- Back-to-back throughput is therefore one access per k+2 cycles.

Ignored and corner inputs:
- mem_ack in IDLE or RESP_*: ignored.
- Requester dropping req during BUSY/RESP: the transaction still completes and valid still pulses (requester must discard).
- rst mid-transaction: return to IDLE with mem_req=0 next cycle; the outstanding access is abandoned; a later stray mem_ack is ignored.

Busy flags:
- Combinational from the req input and the registered valid.
- Both busy flags may be high at once.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds 32-bit outputs stat_if_wait and stat_mm_wait, counting cycles with if_busy or mm_busy high respectively.
  - Adds stat_forced, counting if grants caused by starve_cnt reaching STARVE_MAX.
  - All three saturate at all-ones and clear on rst.
- Undefined: the ports are still present, tied to 0, with no counter logic.

Test Plan:
- Single fetch, memory acks 2 cycles after mem_req: if_req at t0 with addr 0x100, mem_rdata=0xDEADBEEF → mem_req high t1–t2, mem_addr=0x100, mem_we=0, if_valid pulse at t3 with if_rdata=0xDEADBEEF, if_busy low at t3.
- Store: mm_req, mm_we=1, addr 0x40, wdata 0x1234, ack after 1 cycle → mem_we=1, mem_wdata=0x1234, mm_valid pulses once, mm_rdata unchanged.
- Both requesting continuously, ack after 1 cycle, STARVE_MAX=3 → grant order mm,mm,mm,if,mm,mm,mm,if; starve_cnt clears after each if grant.
- STARVE_MAX=0, both requesting → if granted first.
- rst asserted during BUSY_MM, then mem_ack arrives after rst drops → mem_req=0 the next cycle, no mm_valid pulse, state IDLE.
- ARB_STATS_EN, scenario 3 run for 8 grants → stat_forced=2; stat_if_wait equals the count of if_busy-high cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported backing memory between the fetch
// stage (reads) and the memory stage (loads/stores). The memory stage has
// priority, but a starvation counter limits how long fetch can be locked out.
// Each access is a request/ack transaction. Completion is reported by a
// registered one-cycle valid pulse.
// Optional build macro ARB_STATS_EN enables the wait/forced-grant statistic
// counters. When it is undefined, the stat ports are tied to zero.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_busy,
  // memory-stage port
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [DATA_W-1:0] mm_wdata,
  output logic [DATA_W-1:0] mm_rdata,
  output logic              mm_valid,
  output logic              mm_busy,
  // backing memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // statistics
  output logic [31:0]       stat_if_wait,
  output logic [31:0]       stat_mm_wait,
  output logic [31:0]       stat_forced
);

  localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_MM = 3'd2,
    RESP_IF = 3'd3,
    RESP_MM = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_d, mm_rdata_d;
  logic              if_valid_d, mm_valid_d;
  logic              mm_wins;

  // The memory stage wins unless fetch is also waiting and its lockout budget is spent.
  assign mm_wins = mm_req & (~if_req | (starve_cnt < STARVE_LIM));

  // Busy flags feed the stall controller directly.
  assign if_busy = if_req & ~if_valid;
  assign mm_busy = mm_req & ~mm_valid;

  // Next-state and next-register computation.
  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    mem_req_d    = mem_req;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    if_rdata_d   = if_rdata;
    mm_rdata_d   = mm_rdata;
    if_valid_d   = 1'b0;
    mm_valid_d   = 1'b0;

    case (state)
      IDLE: begin
        if (mm_wins) begin
          state_d     = BUSY_MM;
          mem_req_d   = 1'b1;
          mem_we_d    = mm_we;
          mem_addr_d  = mm_addr;
          mem_wdata_d = mm_wdata;
          if (if_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt + CNT_W'(1);
          end
        end else if (if_req) begin
          state_d      = BUSY_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = RESP_IF;
        end
      end

      BUSY_MM: begin
        if (mem_ack) begin
          // A store leaves the previous load data in place.
          if (!mem_we) begin
            mm_rdata_d = mem_rdata;
          end
          mm_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = RESP_MM;
        end
      end

      // The response cycle makes no grant, so a level request still high here is not served twice.
      RESP_IF, RESP_MM: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      mm_rdata   <= '0;
      if_valid   <= 1'b0;
      mm_valid   <= 1'b0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_rdata   <= if_rdata_d;
      mm_rdata   <= mm_rdata_d;
      if_valid   <= if_valid_d;
      mm_valid   <= mm_valid_d;
    end
  end

`ifdef ARB_STATS_EN
  logic forced_if;

  // A fetch grant while mm_req is high happens only when the lockout budget is spent.
  assign forced_if = (state == IDLE) & if_req & mm_req & ~mm_wins;

  // Saturating wait and forced-grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_wait <= '0;
      stat_mm_wait <= '0;
      stat_forced  <= '0;
    end else begin
      if (if_busy && (stat_if_wait != '1)) begin
        stat_if_wait <= stat_if_wait + 32'd1;
      end
      if (mm_busy && (stat_mm_wait != '1)) begin
        stat_mm_wait <= stat_mm_wait + 32'd1;
      end
      if (forced_if && (stat_forced != '1)) begin
        stat_forced <= stat_forced + 32'd1;
      end
    end
  end
`else
  assign stat_if_wait = '0;
  assign stat_mm_wait = '0;
  assign stat_forced  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// It uses a STARVE_MAX=3 instance and a STARVE_MAX=0 instance that share all inputs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mm_req, mm_we, mem_ack;
  logic [31:0] if_addr, mm_addr, mm_wdata, mem_rdata;

  logic [31:0] if_rdata, mm_rdata, mem_addr, mem_wdata;
  logic        if_valid, if_busy, mm_valid, mm_busy, mem_req, mem_we;
  logic [31:0] stat_if_wait, stat_mm_wait, stat_forced;

  logic [31:0] z_if_rdata, z_mm_rdata, z_mem_addr, z_mem_wdata;
  logic        z_if_valid, z_if_busy, z_mm_valid, z_mm_busy, z_mem_req, z_mem_we;
  logic [31:0] z_stat_if_wait, z_stat_mm_wait, z_stat_forced;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_busy(if_busy),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(mm_rdata), .mm_valid(mm_valid), .mm_busy(mm_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stat_if_wait(stat_if_wait), .stat_mm_wait(stat_mm_wait), .stat_forced(stat_forced)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(z_if_rdata),
    .if_valid(z_if_valid), .if_busy(z_if_busy),
    .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
    .mm_rdata(z_mm_rdata), .mm_valid(z_mm_valid), .mm_busy(z_mm_busy),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stat_if_wait(z_stat_if_wait), .stat_mm_wait(z_stat_mm_wait), .stat_forced(z_stat_forced)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances and leave the bench in the first post-reset cycle.
  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mm_req = 1'b0; mm_we = 1'b0; mm_addr = '0; mm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; mm_req = 1'b0; mem_ack = 1'b0;
    step();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (if_rdata !== 32'h0 || mm_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, mm_rdata); end
    n_checks++; if (if_valid !== 1'b0 || mm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b/%b want 0/0", if_valid, mm_valid); end
    n_checks++; if (if_busy !== 1'b0 || mm_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0/0", if_busy, mm_busy); end
    n_checks++; if (stat_if_wait !== 32'h0 || stat_forced !== 32'h0) begin n_fail++; $display("FAIL reset_stats got %h/%h want 0/0", stat_if_wait, stat_forced); end
    rst = 1'b0;
  endtask

  // Single fetch with the memory acking on the second mem_req cycle.
  task automatic test_fetch();
    do_reset();
    if_req = 1'b1; if_addr = 32'h100;               // t0
    step();                                          // t1
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_req_t1 got %b want 1", mem_req); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_mem_addr got %h want 100", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we got %b want 0", mem_we); end
    n_checks++; if (if_busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_t1 got %b want 1", if_busy); end
    step();                                          // t2
    n_checks++; if (mem_req !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_hold_t2 got req=%b valid=%b want 1/0", mem_req, if_valid); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    step();                                          // t3
    mem_ack = 1'b0; mem_rdata = 32'h0;
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch_valid_t3 got %b want 1", if_valid); end
    n_checks++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata got %h want deadbeef", if_rdata); end
    n_checks++; if (if_busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_t3 got %b want 0", if_busy); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_req_t3 got %b want 0", mem_req); end
    step();                                          // t4, request was still high during t3
    if_req = 1'b0;
    n_checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_no_reserve got valid=%b req=%b want 0/0", if_valid, mem_req); end
    step();
  endtask

  // A load sets mm_rdata, then a store must leave it untouched.
  task automatic test_store();
    do_reset();
    mm_req = 1'b1; mm_we = 1'b0; mm_addr = 32'h80;
    step();
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    n_checks++; if (mm_valid !== 1'b1 || mm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL load_resp got valid=%b data=%h want 1/cafef00d", mm_valid, mm_rdata); end
    mm_req = 1'b0;
    step();
    mm_req = 1'b1; mm_we = 1'b1; mm_addr = 32'h40; mm_wdata = 32'h1234;
    step();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL store_req got req=%b we=%b want 1/1", mem_req, mem_we); end
    n_checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL store_payload got %h/%h want 40/1234", mem_addr, mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    step();
    mem_ack = 1'b0;
    n_checks++; if (mm_valid !== 1'b1) begin n_fail++; $display("FAIL store_valid got %b want 1", mm_valid); end
    n_checks++; if (mm_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_rdata_kept got %h want cafef00d", mm_rdata); end
    mm_req = 1'b0; mm_we = 1'b0;
    step();
    n_checks++; if (mm_valid !== 1'b0) begin n_fail++; $display("FAIL store_single_pulse got %b want 0", mm_valid); end
  endtask

  // Both requesting continuously with k=1. The main instance alternates three mm grants with one if grant.
  // The STARVE_MAX=0 instance always serves fetch.
  task automatic test_fairness();
    logic exp_if [8];
    logic [31:0] exp_addr;
    for (int i = 0; i < 8; i++) exp_if[i] = (i == 3 || i == 7);
    do_reset();
    if_req = 1'b1; if_addr = 32'h200;
    mm_req = 1'b1; mm_we = 1'b0; mm_addr = 32'h300;
    for (int g = 0; g < 8; g++) begin
      step();                                        // BUSY
      exp_addr = exp_if[g] ? 32'h200 : 32'h300;
      n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL grant_order[%0d] got %h want %h", g, mem_addr, exp_addr); end
      n_checks++; if (z_mem_addr !== 32'h200 || z_mem_req !== 1'b1) begin n_fail++; $display("FAIL starve0_grant[%0d] got addr=%h req=%b want 200/1", g, z_mem_addr, z_mem_req); end
      mem_ack = 1'b1; mem_rdata = 32'hA000_0000 + 32'(g);
      step();                                        // RESP
      mem_ack = 1'b0;
      n_checks++; if (if_valid !== exp_if[g] || mm_valid !== !exp_if[g]) begin n_fail++; $display("FAIL grant_valid[%0d] got if=%b mm=%b want if=%b", g, if_valid, mm_valid, exp_if[g]); end
      step();                                        // IDLE
    end
`ifdef ARB_STATS_EN
    n_checks++; if (stat_forced !== 32'd2) begin n_fail++; $display("FAIL stat_forced got %0d want 2", stat_forced); end
    n_checks++; if (stat_if_wait !== 32'd22) begin n_fail++; $display("FAIL stat_if_wait got %0d want 22", stat_if_wait); end
    n_checks++; if (stat_mm_wait !== 32'd18) begin n_fail++; $display("FAIL stat_mm_wait got %0d want 18", stat_mm_wait); end
    n_checks++; if (z_stat_forced !== 32'd8 || z_stat_if_wait !== 32'd16) begin n_fail++; $display("FAIL starve0_stats got forced=%0d ifw=%0d want 8/16", z_stat_forced, z_stat_if_wait); end
`else
    n_checks++; if (stat_forced !== 32'd0 || stat_if_wait !== 32'd0 || stat_mm_wait !== 32'd0) begin n_fail++; $display("FAIL stats_tied got %h/%h/%h want 0", stat_forced, stat_if_wait, stat_mm_wait); end
`endif
    if_req = 1'b0; mm_req = 1'b0;
    step();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fairness_drain got %b want 0", mem_req); end
  endtask

  // Reset during BUSY_MM abandons the access, and a later stray ack is ignored.
  task automatic test_reset_mid();
    do_reset();
    mm_req = 1'b1; mm_we = 1'b0; mm_addr = 32'h500;
    step();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b want 1", mem_req); end
    rst = 1'b1;
    step();
    n_checks++; if (mem_req !== 1'b0 || mm_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_abort got req=%b valid=%b want 0/0", mem_req, mm_valid); end
    rst = 1'b0; mm_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0;
    n_checks++; if (mm_valid !== 1'b0 || mm_rdata !== 32'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_stray_ack got valid=%b data=%h req=%b want 0/0/0", mm_valid, mm_rdata, mem_req); end
    if_req = 1'b1; if_addr = 32'h600;
    step();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin n_fail++; $display("FAIL rmid_idle_grant got req=%b addr=%h want 1/600", mem_req, mem_addr); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; if_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
